// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage with an internal instruction memory and a small
// FIFO between fetch and decode. The PC advances whenever there is room in
// the queue, or whenever an entry leaves it. Decode drains the queue through a
// valid/ready handshake. A taken redirect from decode flushes the queue and
// restarts fetch at the word-aligned target.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_POWER = 18,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       PCSrcD,
  input  logic [XLEN-1:0]            pcnD,
  input  logic                       readyD,
  output logic [XLEN-1:0]            pcD,
  output logic [XLEN-1:0]            instrD,
  output logic                       validD,
  output logic [$clog2(QDEPTH+1)-1:0] countF,
  output logic [XLEN-1:0]            pcF
);

  localparam int PW        = $clog2(QDEPTH);
  localparam int CW        = $clog2(QDEPTH + 1);
  localparam int MEM_DEPTH = 1 << IMEM_POWER;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

  // Instruction memory; the contents are loaded from outside before use.
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fifo_pc_q    [QDEPTH];
  logic [XLEN-1:0] fifo_pc_d    [QDEPTH];
  logic [XLEN-1:0] fifo_instr_q [QDEPTH];
  logic [XLEN-1:0] fifo_instr_d [QDEPTH];

  logic [IMEM_POWER-1:0] mem_idx;
  logic [XLEN-1:0]       fetch_instr;
  logic                  valid;
  logic                  do_push;
  logic                  do_pop;
  logic                  unused_pcn_bits;

  // Word index into memory; upper PC bits alias back onto the array.
  assign mem_idx     = pc_q[IMEM_POWER+1:2];
  assign fetch_instr = mem[mem_idx];
  assign valid       = (count_q != '0);

  // Redirect targets are forced to word alignment, so the low bits are dropped.
  assign unused_pcn_bits = ^pcnD[1:0];

  // Next-state for PC, pointers, occupancy and queue storage; redirect beats push/pop.
  always_comb begin
    pc_d         = pc_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    do_push      = 1'b0;
    do_pop       = 1'b0;

    if (en) begin
      if (PCSrcD) begin
        rd_d    = '0;
        wr_d    = '0;
        count_d = '0;
        pc_d    = {pcnD[XLEN-1:2], 2'b00};
      end else begin
        do_pop  = valid & readyD;
        do_push = (count_q < FULL_COUNT) | do_pop;

        if (do_push) begin
          fifo_pc_d[wr_q]    = pc_q;
          fifo_instr_d[wr_q] = fetch_instr;
          wr_d               = wr_q + PW'(1);
          pc_d               = pc_q + XLEN'(4);
        end

        if (do_pop) begin
          rd_d = rd_q + PW'(1);
        end

        count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  // State registers with asynchronous reset to an empty queue at RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // Head entry comes straight from queue registers; it reads zero while empty.
  assign validD = valid;
  assign pcD    = valid ? fifo_pc_q[rd_q]    : '0;
  assign instrD = valid ? fifo_instr_q[rd_q] : '0;
  assign countF = count_q;
  assign pcF    = pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by random traffic, with every
// output compared against a queue-based reference model of the fetch stage.
module tb_fetch_queue;

  localparam int XLEN   = 32;
  localparam int IMP    = 8;
  localparam int QDEPTH = 4;
  localparam int MDEPTH = 1 << IMP;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] pcnD = '0;
  logic        readyD = 1'b0;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;
  logic [2:0]  countF;
  logic [31:0] pcF;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_mem [MDEPTH];
  entry_t      mq[$];
  logic [31:0] m_pc;
  logic [31:0] saved_pc;

  fetch_queue #(
    .XLEN(XLEN),
    .IMEM_POWER(IMP),
    .QDEPTH(QDEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .PCSrcD(PCSrcD),
    .pcnD(pcnD),
    .readyD(readyD),
    .pcD(pcD),
    .instrD(instrD),
    .validD(validD),
    .countF(countF),
    .pcF(pcF)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one enabled/disabled clock edge.
  task automatic modelStep(input logic e, input logic s, input logic [31:0] n, input logic r);
    logic   pop;
    logic   push;
    entry_t ent;
    if (!e) return;
    if (s) begin
      mq.delete();
      m_pc = {n[31:2], 2'b00};
    end else begin
      pop  = (mq.size() != 0) && r;
      push = (mq.size() < QDEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        ent.pc    = m_pc;
        ent.instr = model_mem[m_pc[IMP+1:2]];
        mq.push_back(ent);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("pcF", 64'(pcF), 64'(m_pc));
    checkOutput("countF", 64'(countF), 64'(mq.size()));
    checkOutput("validD", 64'(validD), 64'(mq.size() != 0));
    checkOutput("pcD", 64'(pcD), (mq.size() != 0) ? 64'(mq[0].pc) : 64'd0);
    checkOutput("instrD", 64'(instrD), (mq.size() != 0) ? 64'(mq[0].instr) : 64'd0);
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic [31:0] n, input logic r);
    en     = e;
    PCSrcD = s;
    pcnD   = n;
    readyD = r;
    @(posedge clk);
    modelStep(e, s, n, r);
    #1;
    compareAll();
  endtask

  // Called 1 time unit after an edge: pulse reset between edges.
  task automatic asyncReset();
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    m_pc = 32'h0;
    checkOutput("rst_validD", 64'(validD), 64'd0);
    checkOutput("rst_pcF", 64'(pcF), 64'd0);
    checkOutput("rst_countF", 64'(countF), 64'd0);
    checkOutput("rst_pcD", 64'(pcD), 64'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MDEPTH; i++) begin
      model_mem[i] = $urandom;
      dut.mem[i]   = model_mem[i];
    end
    m_pc = 32'h0;

    #2;
    reset = 1'b1;
    #1;
    compareAll();
    @(posedge clk);
    #3;
    reset = 1'b0;

    // Streaming with decode always ready: one entry in flight.
    applyStimulus(1, 0, 0, 1);
    checkOutput("s1_pcD", 64'(pcD), 64'd0);
    checkOutput("s1_instrD", 64'(instrD), 64'(model_mem[0]));
    applyStimulus(1, 0, 0, 1);
    checkOutput("s2_pcD", 64'(pcD), 64'd4);
    checkOutput("s2_instrD", 64'(instrD), 64'(model_mem[1]));
    applyStimulus(1, 0, 0, 1);
    checkOutput("s3_pcD", 64'(pcD), 64'd8);
    checkOutput("s3_countF", 64'(countF), 64'd1);

    // Decode stalled from reset: queue fills and fetch stops at 16.
    asyncReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("fill_countF", 64'(countF), (i < 4) ? 64'(i) : 64'd4);
    end
    checkOutput("full_pcF", 64'(pcF), 64'd16);
    checkOutput("full_pcD", 64'(pcD), 64'd0);

    // One pop while full: head advances, count stays, fetch moves on.
    applyStimulus(1, 0, 0, 1);
    checkOutput("fpop_pcD", 64'(pcD), 64'd4);
    checkOutput("fpop_countF", 64'(countF), 64'd4);
    checkOutput("fpop_pcF", 64'(pcF), 64'd20);

    // Redirect with three entries queued, target misaligned.
    asyncReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 32'h103, 0);
    checkOutput("redir_countF", 64'(countF), 64'd0);
    checkOutput("redir_validD", 64'(validD), 64'd0);
    checkOutput("redir_pcF", 64'(pcF), 64'h100);
    applyStimulus(1, 0, 0, 0);
    checkOutput("tgt_pcD", 64'(pcD), 64'h100);
    checkOutput("tgt_instrD", 64'(instrD), 64'(model_mem[8'h40]));

    // Redirect together with a pop: the flush wins.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 32'h200, 1);
    checkOutput("rpop_countF", 64'(countF), 64'd0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Enable low: everything frozen, redirect ignored, then reset between edges.
    saved_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h3c, 1);
      checkOutput("hold_pcF", 64'(pcF), 64'(saved_pc));
    end
    asyncReset();

    // Random traffic, occasionally interrupted by reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                    $urandom, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) asyncReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
